// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch control stage with IF/ID register
//
// Sits after the PC register: issues imem fetches at pc_if, computes the next
// PC, and owns the IF/ID pipeline register plus a 1-entry hold buffer used
// when ID stalls while a fetch returns.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_if               current PC from the PC register
//   pc_next, pc_ce      D and write enable for the PC register
//   imem_req/addr       fetch request and address (address is pc_if)
//   imem_ready/rdata    fetch response (variable latency)
//   id_stall            ID cannot accept a new instruction
//   redirect/_pc        taken branch/jump from ID and its target
//   ifid_pc/pc4/inst    IF/ID register contents
//   ifid_valid          IF/ID holds a real instruction
module if_fetch_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic [31:0] pc_next,
  output logic        pc_ce,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // REQ/WAIT: fetch outstanding at pc_if; HOLD: data parked, waiting for ID;
  // DROP: a fetch issued before a redirect is still in flight and is discarded.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] hold_q;
  logic [31:0] pc_seq;
  logic        req_c, ce_c;
  logic        load_c;     // write a real instruction into IF/ID
  logic        capture_c;  // park imem_rdata in the hold buffer
  logic        bubble_c;   // ID drained it and nothing arrived: invalidate
  logic        flush_c;

  assign pc_seq    = pc_if + STEP;  // 32-bit modulo, wraps past 0xFFFFFFFC
  assign pc_next   = redirect ? redirect_pc : pc_seq;
  assign imem_addr = pc_if;
  // Request and PC enable are forced low for the whole reset assertion.
  assign imem_req  = req_c & rst_n;
  assign pc_ce     = ce_c & rst_n;

  always_comb begin
    state_nx  = state;
    req_c     = 1'b0;
    ce_c      = 1'b0;
    load_c    = 1'b0;
    capture_c = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;

    case (state)
      S_REQ, S_WAIT: begin
        req_c = 1'b1;
        if (!redirect) begin
          if (imem_ready) begin
            if (!id_stall) begin
              load_c   = 1'b1;
              ce_c     = 1'b1;
              state_nx = S_REQ;
            end else begin
              capture_c = 1'b1;
              state_nx  = S_HOLD;
            end
          end else begin
            state_nx = S_WAIT;
            bubble_c = !id_stall;
          end
        end
      end
      S_HOLD: begin
        // imem_ready here has no outstanding request behind it; ignored.
        if (!redirect && !id_stall) begin
          load_c   = 1'b1;
          ce_c     = 1'b1;
          state_nx = S_REQ;
        end
      end
      S_DROP: begin
        if (!redirect && imem_ready) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase

    // Redirect overrides everything above: flush IF/ID and steer the PC.
    if (redirect) begin
      ce_c    = 1'b1;
      flush_c = 1'b1;
      case (state)
        S_HOLD:  state_nx = S_REQ;
        default: state_nx = imem_ready ? S_REQ : S_DROP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      hold_q     <= 32'h0;
      ifid_pc    <= 32'h0;
      ifid_pc4   <= 32'h0;
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (flush_c) begin
        ifid_inst  <= NOP_INST;
        ifid_valid <= 1'b0;
        hold_q     <= 32'h0;
      end else if (load_c) begin
        ifid_pc    <= pc_if;
        ifid_pc4   <= pc_seq;
        ifid_inst  <= (state == S_HOLD) ? hold_q : imem_rdata;
        ifid_valid <= 1'b1;
      end else begin
        if (capture_c) hold_q <= imem_rdata;
        if (bubble_c) ifid_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic [31:0] pc_next;
  logic        pc_ce;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_inst;
  logic        ifid_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what IF/ID should hold, plus whether a fetched word is
  // parked waiting for ID and whether an orphaned fetch must be swallowed.
  logic [31:0] m_pc, m_pc4, m_inst, m_word;
  bit          m_valid, m_parked, m_orphan;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_if(pc_if), .pc_next(pc_next), .pc_ce(pc_ce),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_inst(ifid_inst), .ifid_valid(ifid_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_pc4 = 0; m_inst = 0; m_word = 0;
    m_valid = 0; m_parked = 0; m_orphan = 0;
  endtask

  task automatic check_ifid();
    check("ifid_pc", ifid_pc, m_pc);
    check("ifid_pc4", ifid_pc4, m_pc4);
    check("ifid_inst", ifid_inst, m_inst);
    check("ifid_valid", ifid_valid, m_valid);
  endtask

  // One clock: drive inputs after the falling edge, check the combinational
  // outputs, then after the rising edge act as the PC register and check IF/ID.
  task automatic step(input bit st, input bit rdy, input logic [31:0] rd,
                      input bit rdr, input logic [31:0] rpc);
    logic [31:0] e_next, cur_pc;
    bit e_req, e_ce;
    @(negedge clk);
    id_stall = st; imem_ready = rdy; imem_rdata = rd; redirect = rdr; redirect_pc = rpc;
    #1;
    cur_pc = pc_if;
    e_req  = !m_parked && !m_orphan;
    e_next = rdr ? rpc : cur_pc + 32'd4;
    e_ce   = rdr || (m_parked && !st) || (e_req && rdy && !st);
    check("imem_req", imem_req, e_req);
    check("imem_addr", imem_addr, cur_pc);
    check("pc_ce", pc_ce, e_ce);
    if (e_ce) check("pc_next", pc_next, e_next);
    @(posedge clk);
    #1;
    if (rdr) begin
      m_inst = 0; m_valid = 0;
      m_orphan = !m_parked && !rdy;
      m_parked = 0;
    end else if (m_parked) begin
      if (!st) begin
        m_pc = cur_pc; m_pc4 = cur_pc + 32'd4; m_inst = m_word; m_valid = 1; m_parked = 0;
      end
    end else if (m_orphan) begin
      if (rdy) m_orphan = 0;
    end else if (rdy && !st) begin
      m_pc = cur_pc; m_pc4 = cur_pc + 32'd4; m_inst = rd; m_valid = 1;
    end else if (rdy) begin
      m_parked = 1; m_word = rd;
    end else if (!st) begin
      m_valid = 0;
    end
    if (e_ce) pc_if = e_next;
    check_ifid();
  endtask

  initial begin
    rst_n = 1'b0; pc_if = 0; imem_ready = 0; imem_rdata = 0;
    id_stall = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    #12;
    check("rst imem_req", imem_req, 1'b0);
    check("rst pc_ce", pc_ce, 1'b0);
    check_ifid();
    @(negedge clk); rst_n = 1'b1;

    // Zero-wait stream
    step(0, 1, 32'h11111111, 0, 0);
    step(0, 1, 32'h22222222, 0, 0);
    check("stream inst", ifid_inst, 32'h22222222);
    check("stream pc4", ifid_pc4, 32'h8);

    // Wait states at 0x100
    pc_if = 32'h100;
    repeat (3) step(0, 0, 32'h0, 0, 0);
    step(0, 1, 32'h33333333, 0, 0);
    check("wait ifid_pc", ifid_pc, 32'h100);

    // Stall hold
    step(1, 1, 32'hAAAA5555, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 0, 0);
    check("hold inst", ifid_inst, 32'hAAAA5555);

    // Redirect during WAIT, late data dropped
    pc_if = 32'h200;
    step(0, 0, 32'h0, 0, 0);
    step(0, 0, 32'h0, 1, 32'h400);
    step(0, 0, 32'h0, 0, 0);
    step(0, 1, 32'hDEADBEEF, 0, 0);
    step(0, 1, 32'h44444444, 0, 0);
    check("redir ifid_pc", ifid_pc, 32'h400);
    check("redir inst", ifid_inst, 32'h44444444);

    // Redirect with simultaneous ready+stall: hold must not be loaded
    step(1, 1, 32'h55555555, 1, 32'h800);
    step(0, 1, 32'h66666666, 0, 0);
    check("redir2 ifid_pc", ifid_pc, 32'h800);
    check("redir2 inst", ifid_inst, 32'h66666666);

    // Wrap
    pc_if = 32'hFFFFFFFC;
    step(0, 1, 32'h77777777, 0, 0);
    check("wrap pc4", ifid_pc4, 32'h0);
    check("wrap pc_if", pc_if, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = $urandom() & 32'hFFFFFFFC;
      step($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, $urandom(),
           $urandom_range(0, 9) == 0, tgt);
    end

    // Reset asserted mid-WAIT: takes effect without a clock edge
    step(0, 1, 32'h88888888, 0, 0);
    step(0, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst imem_req", imem_req, 1'b0);
    check("midrst pc_ce", pc_ce, 1'b0);
    check_ifid();
    imem_ready = 0; id_stall = 0; redirect = 0; pc_if = 0;
    @(negedge clk); rst_n = 1'b1;
    step(0, 1, 32'h99999999, 0, 0);
    check("post-rst inst", ifid_inst, 32'h99999999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
